// File: rtl/control_word_sequencer.sv
// Loadable control-word buffer that replays FS/WR/DA/SA/SB words into the
// register file and ALU, one per clock (run) or one per step pulse.
module control_word_sequencer #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  load,
  input  logic [15:0]           load_data,
  input  logic                  start,
  input  logic                  step,
  output logic [4:0]            FS,
  output logic                  WR,
  output logic [2:0]            DA,
  output logic [2:0]            SA,
  output logic [2:0]            SB,
  output logic [DEPTH_LOG2-1:0] pc,
  output logic [DEPTH_LOG2:0]   word_count,
  output logic                  running,
  output logic                  halted
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t                state, state_next;
  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [15:0]           word;
  logic [DEPTH_LOG2:0]   pc_inc;
  logic                  empty, last, issue, restart, do_load;

  always_ff @(posedge clock) begin
    if (reset || clear) state <= IDLE;
    else                state <= state_next;
  end

  // Terminate when the issued word carries HALT or the buffer is exhausted;
  // pc_inc is one bit wider so a full buffer ends when pc wraps.
  always_comb begin
    word       = mem[pc];
    pc_inc     = {1'b0, pc} + COUNT_ONE;
    empty      = (word_count == '0);
    last       = word[15] || (pc_inc == word_count);
    state_next = state;
    issue      = 1'b0;
    restart    = 1'b0;
    do_load    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (empty) state_next = HALTED;
          else begin
            state_next = RUN;
            restart    = 1'b1;
          end
        end else if (step) begin
          if (!empty) begin
            issue = 1'b1;
            if (last) state_next = HALTED;
          end
        end else if (load) begin
          do_load = 1'b1;
        end
      end
      RUN: begin
        issue = 1'b1;
        if (last) state_next = HALTED;
      end
      HALTED: begin
        if (start && !empty) begin
          state_next = RUN;
          restart    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    running = (state == RUN);
    halted  = (state == HALTED);
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      pc         <= '0;
      wptr       <= '0;
      word_count <= '0;
      FS         <= '0;
      WR         <= 1'b0;
      DA         <= '0;
      SA         <= '0;
      SB         <= '0;
    end else begin
      WR <= 1'b0;
      if (restart) pc <= '0;
      if (issue) begin
        FS <= word[14:10];
        WR <= word[9];
        DA <= word[8:6];
        SA <= word[5:3];
        SB <= word[2:0];
        pc <= pc + PTR_ONE;
      end
      if (do_load) begin
        wptr <= wptr + PTR_ONE;
        if (word_count != COUNT_FULL) word_count <= word_count + COUNT_ONE;
      end
    end
  end

  // Buffer contents survive reset and clear.
  always_ff @(posedge clock) begin
    if (do_load && !reset && !clear) mem[wptr] <= load_data;
  end

endmodule

// File: tb/tb_control_word_sequencer.sv
// Directed and randomized checks of control_word_sequencer against a
// cycle-level behavioural model of the load/run/step/halt rules.
module tb_control_word_sequencer;

  logic        clock = 1'b0;
  logic        reset, clear, load, start, step;
  logic [15:0] load_data;
  logic [4:0]  FS;
  logic        WR;
  logic [2:0]  DA, SA, SB;
  logic [3:0]  pc;
  logic [4:0]  word_count;
  logic        running, halted;

  control_word_sequencer #(.DEPTH_LOG2(4)) dut (
    .clock(clock), .reset(reset), .clear(clear), .load(load),
    .load_data(load_data), .start(start), .step(step),
    .FS(FS), .WR(WR), .DA(DA), .SA(SA), .SB(SB),
    .pc(pc), .word_count(word_count), .running(running), .halted(halted)
  );

  always #5 clock = ~clock;

  localparam int M_IDLE = 0, M_RUN = 1, M_HALTED = 2;

  int          compareCount = 0;
  int          mismatchCount = 0;
  int          wrSeen = 0;
  int          runSeen = 0;
  logic [15:0] mMem [16];
  int          mMode, mPc, mWptr, mCount;
  int          mFs, mWr, mDa, mSa, mSb;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // One clock edge of the reference behaviour, applied in priority order.
  task automatic modelEdge(input logic r, input logic c, input logic l,
                           input logic [15:0] d, input logic s, input logic st);
    logic [15:0] w;
    bit          doIssue;
    doIssue = 0;
    if (r || c) begin
      mMode = M_IDLE; mPc = 0; mWptr = 0; mCount = 0;
      mFs = 0; mWr = 0; mDa = 0; mSa = 0; mSb = 0;
    end else begin
      mWr = 0;
      if (mMode == M_IDLE) begin
        if (s) begin
          if (mCount == 0) mMode = M_HALTED;
          else begin mMode = M_RUN; mPc = 0; end
        end else if (st) begin
          if (mCount > 0) doIssue = 1;
        end else if (l) begin
          mMem[mWptr] = d;
          mWptr = (mWptr + 1) % 16;
          if (mCount < 16) mCount++;
        end
      end else if (mMode == M_RUN) begin
        doIssue = 1;
      end else begin
        if (s && mCount > 0) begin mMode = M_RUN; mPc = 0; end
      end
      if (doIssue) begin
        w   = mMem[mPc];
        mFs = int'(w[14:10]);
        mWr = int'(w[9]);
        mDa = int'(w[8:6]);
        mSa = int'(w[5:3]);
        mSb = int'(w[2:0]);
        if (w[15] || (mPc + 1) == mCount) mMode = M_HALTED;
        mPc = (mPc + 1) % 16;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic c, input logic l,
                               input logic [15:0] d, input logic s, input logic st);
    reset = r; clear = c; load = l; load_data = d; start = s; step = st;
    @(posedge clock);
    modelEdge(r, c, l, d, s, st);
    #1;
    checkOutput("FS", FS, mFs);
    checkOutput("WR", WR, mWr);
    checkOutput("DA", DA, mDa);
    checkOutput("SA", SA, mSa);
    checkOutput("SB", SB, mSb);
    checkOutput("pc", pc, mPc);
    checkOutput("word_count", word_count, mCount);
    checkOutput("running", running, mMode == M_RUN);
    checkOutput("halted", halted, mMode == M_HALTED);
    if (WR === 1'b1) wrSeen++;
    if (running === 1'b1) runSeen++;
  endtask

  task automatic idleCycle(); applyStimulus(0, 0, 0, 16'h0, 0, 0); endtask
  task automatic doLoad(input logic [15:0] d); applyStimulus(0, 0, 1, d, 0, 0); endtask
  task automatic doStart(); applyStimulus(0, 0, 0, 16'h0, 1, 0); endtask
  task automatic doStep(); applyStimulus(0, 0, 0, 16'h0, 0, 1); endtask
  task automatic doClear(); applyStimulus(0, 1, 0, 16'h0, 0, 0); endtask

  task automatic checkThreeWordRun(input string tag);
    runSeen = 0;
    doStart();
    idleCycle();
    checkOutput({tag, "_w0_WR"}, WR, 1);
    checkOutput({tag, "_w0_DA"}, DA, 1);
    checkOutput({tag, "_w0_SA"}, SA, 2);
    checkOutput({tag, "_w0_SB"}, SB, 3);
    checkOutput({tag, "_w0_FS"}, FS, 0);
    idleCycle();
    checkOutput({tag, "_w1_WR"}, WR, 0);
    checkOutput({tag, "_w1_FS"}, FS, 5);
    checkOutput({tag, "_w1_DA"}, DA, 2);
    checkOutput({tag, "_w1_SA"}, SA, 1);
    checkOutput({tag, "_w1_SB"}, SB, 0);
    idleCycle();
    checkOutput({tag, "_w2_WR"}, WR, 0);
    checkOutput({tag, "_w2_FS"}, FS, 0);
    checkOutput({tag, "_w2_halted"}, halted, 1);
    idleCycle();
    checkOutput({tag, "_run_cycles"}, runSeen, 3);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mMem[i] = 16'h0;
    mMode = M_IDLE; mPc = 0; mWptr = 0; mCount = 0;
    mFs = 0; mWr = 0; mDa = 0; mSa = 0; mSb = 0;

    applyStimulus(1, 0, 0, 16'h0, 0, 0);
    checkOutput("reset_word_count", word_count, 0);
    checkOutput("reset_halted", halted, 0);

    wrSeen = 0;
    doStart();
    checkOutput("empty_start_halted", halted, 1);
    idleCycle();
    idleCycle();
    checkOutput("empty_start_no_wr", wrSeen, 0);
    doClear();

    doLoad(16'h0253);
    doLoad(16'h1488);
    doLoad(16'h8000);
    checkOutput("three_loads_count", word_count, 3);
    checkThreeWordRun("run");
    checkThreeWordRun("replay");

    doClear();
    doLoad(16'h0253);
    doLoad(16'h0253);
    doStep();
    checkOutput("step1_WR", WR, 1);
    checkOutput("step1_pc", pc, 1);
    idleCycle();
    checkOutput("step1_WR_drop", WR, 0);
    doStep();
    checkOutput("step2_WR", WR, 1);
    checkOutput("step2_pc", pc, 2);
    checkOutput("step2_halted", halted, 1);
    doStep();
    checkOutput("step3_WR", WR, 0);
    checkOutput("step3_pc", pc, 2);

    doClear();
    for (int k = 0; k < 17; k++) doLoad(16'h0200 | 16'(k));
    checkOutput("full_count", word_count, 16);
    wrSeen = 0;
    doStart();
    idleCycle();
    checkOutput("full_first_SB", SB, 0);
    checkOutput("full_first_SA", SA, 2);
    for (int k = 0; k < 16; k++) idleCycle();
    checkOutput("full_wr_cycles", wrSeen, 16);
    checkOutput("full_halted", halted, 1);
    checkOutput("full_pc_wrap", pc, 0);

    doClear();
    doLoad(16'h0253);
    doLoad(16'h1488);
    doLoad(16'h0A49);
    doStart();
    idleCycle();
    doClear();
    checkOutput("midrun_clear_WR", WR, 0);
    checkOutput("midrun_clear_running", running, 0);
    checkOutput("midrun_clear_pc", pc, 0);
    checkOutput("midrun_clear_count", word_count, 0);
    doStart();
    checkOutput("after_clear_start_halted", halted, 1);

    for (int n = 0; n < 1500; n++) begin
      logic [15:0] d;
      d = 16'($urandom);
      d[15] = ($urandom_range(0, 7) == 0);
      applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 39) == 0,
                    $urandom_range(0, 3) == 0, d,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
